fifo_teclas: RTL

- Buffers hex keypad codes from the keypad interface so that keypresses are not lost while the consumer is busy.
- Sits directly downstream of the keypad interface top. It takes that block's registered data-available level and its 4-bit encoded key.
- Each rising edge of data-available pushes exactly one code into a show-ahead FIFO.
- The consumer (display/digit-assembly logic) drains the FIFO through a valid/ready handshake.

---
 rtl/fifo_teclas.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_teclas.sv
// fifo_teclas: show-ahead FIFO buffering keypad codes, one push per rising edge of data_available_i.
// Define FIFO_TECLAS_OVERWRITE_EN to discard the oldest entry on a push while full (default drops the new code).
module fifo_teclas #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     data_available_i,
  input  logic [3:0]               dato_codificado_i,
  input  logic                     rd_ready_i,
  input  logic                     clear_overflow_i,
  output logic                     rd_valid_o,
  output logic [3:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic          da_q;
  logic          push;
  logic          pop;
  logic          accept;
  logic          ovf_evt;
  logic          wr_en;
  logic          rd_adv;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          overflow_q;
  logic [3:0]    mem [DEPTH];

  // Flags decode straight from the count register, so they move on the same edge as the count.
  assign full_o     = (count_q == FULL_COUNT);
  assign empty_o    = (count_q == '0);
  assign rd_valid_o = ~empty_o;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem[rd_ptr];

  assign push = data_available_i & ~da_q;
  assign pop  = rd_valid_o & rd_ready_i;

  // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
  always_comb begin
    ovf_evt   = push & full_o & ~pop;
    accept    = push & (~full_o | pop);
`ifdef FIFO_TECLAS_OVERWRITE_EN
    wr_en     = accept | ovf_evt;
    rd_adv    = pop | ovf_evt;
`else
    wr_en     = accept;
    rd_adv    = pop;
`endif
    count_nxt = count_q;
    if (accept && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (pop && !accept) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      da_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      da_q    <= data_available_i;
      count_q <= count_nxt;
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A simultaneous overflow event wins over the clear request.
      if (ovf_evt) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // NOTE: storage is deliberately not reset; rd_valid_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= dato_codificado_i;
    end
  end

endmodule
